// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/ID pipeline register for the 16-bit MiniMips core.
// Runs the imem request/valid handshake, absorbs stalls with a one-entry skid buffer, applies redirects.
module fetch_decode_stage #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_rdata,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [PC_WIDTH-1:0] id_pc_next,
  output logic [3:0]          id_opcode,
  output logic [2:0]          id_rs,
  output logic [2:0]          id_rt,
  output logic [2:0]          id_rd,
  output logic [2:0]          id_funct,
  output logic [5:0]          id_imm6
);

  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [PC_WIDTH-1:0] pc, pc_d, pc_inc;
  logic [PC_WIDTH-1:0] skid_pc, sel_pc;
  logic [INSTR_W-1:0]  skid_instr, id_instr, sel_instr;
  logic                id_load, id_kill, skid_load, skid_clr;

  assign pc_inc    = pc + PC_WIDTH'(PC_STEP);
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  // Field split of the latched instruction word
  assign id_opcode = id_instr[15:12];
  assign id_rs     = id_instr[11:9];
  assign id_rt     = id_instr[8:6];
  assign id_rd     = id_instr[5:3];
  assign id_funct  = id_instr[2:0];
  assign id_imm6   = id_instr[5:0];

  // Next state, next pc and IF/ID / skid control
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    id_load   = 1'b0;
    id_kill   = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    sel_pc    = pc;
    sel_instr = imem_rdata;
    unique case (state)
      BOOT: begin
        state_d = FETCH;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = BOOT;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          pc_d     = branch_target;
          id_kill  = 1'b1;
          skid_clr = 1'b1;
          state_d  = BOOT;
        end else if (imem_valid) begin
          if (stall) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            id_load = 1'b1;
            pc_d    = pc_inc;
          end
        end else if (!stall) begin
          id_kill = 1'b1;
        end
      end
      HOLD: begin
        sel_pc    = skid_pc;
        sel_instr = skid_instr;
        if (branch_taken) begin
          pc_d     = branch_target;
          id_kill  = 1'b1;
          skid_clr = 1'b1;
          state_d  = BOOT;
        end else if (!stall) begin
          id_load = 1'b1;
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_d;
      pc    <= pc_d;
    end
  end

  // Skid buffer and IF/ID register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_pc    <= '0;
      skid_instr <= '0;
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_pc_next <= '0;
      id_instr   <= '0;
    end else begin
      if (skid_load) begin
        skid_pc    <= pc;
        skid_instr <= imem_rdata;
      end else if (skid_clr) begin
        skid_pc    <= '0;
        skid_instr <= '0;
      end
      if (id_load) begin
        id_valid   <= 1'b1;
        id_pc      <= sel_pc;
        id_pc_next <= sel_pc + PC_WIDTH'(PC_STEP);
        id_instr   <= sel_instr;
      end else if (id_kill) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: table of decoded words plus hand sequences for stall, redirect, reset and wrap.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_next;
  logic [3:0]  id_opcode;
  logic [2:0]  id_rs, id_rt, id_rd, id_funct;
  logic [5:0]  id_imm6;

  fetch_decode_stage dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_next(id_pc_next),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_imm6(id_imm6)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] word;
    logic [3:0]  op;
    logic [2:0]  rs, rt, rd, fn;
    logic [5:0]  imm;
  } exp_t;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  op;
    logic [2:0]  rs, rt, rd, fn;
    logic [5:0]  imm;
  } vec_t;

  exp_t sbq[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [15:0] w);
    exp_t e;
    e.pc = pc; e.word = w;
    e.op = w[15:12]; e.rs = w[11:9]; e.rt = w[8:6]; e.rd = w[5:3]; e.fn = w[2:0]; e.imm = w[5:0];
    return e;
  endfunction

  // One clock edge; a live id_valid after an unstalled edge is a new instruction
  task automatic step();
    logic st;
    exp_t e;
    st = stall;
    @(posedge clk);
    #1;
    if (!st && id_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got id_pc=%h, required no new instruction", id_pc);
      end else begin
        e = sbq.pop_front();
        last = e;
        chk("id_pc", id_pc, e.pc);
        chk("id_pc_next", id_pc_next, e.pc + 32'd2);
        chk("id_opcode", 32'(id_opcode), 32'(e.op));
        chk("id_rs", 32'(id_rs), 32'(e.rs));
        chk("id_rt", 32'(id_rt), 32'(e.rt));
        chk("id_rd", 32'(id_rd), 32'(e.rd));
        chk("id_funct", 32'(id_funct), 32'(e.fn));
        chk("id_imm6", 32'(id_imm6), 32'(e.imm));
      end
    end
  endtask

  // Memory answers the request at rec.pc this cycle
  task automatic respond(input exp_t rec, input logic stl, input logic keep);
    chk("resp_req", 32'(imem_req), 32'd1);
    chk("resp_addr", imem_addr, rec.pc);
    imem_valid = 1'b1;
    imem_rdata = rec.word;
    stall      = stl;
    if (keep) sbq.push_back(rec);
    step();
    imem_valid = 1'b0;
    imem_rdata = 16'h0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_valid"}, 32'(id_valid), 32'd0);
    chk({pfx, "_pc"}, id_pc, 32'd0);
    chk({pfx, "_pc_next"}, id_pc_next, 32'd0);
    chk({pfx, "_fields"}, 32'({id_opcode, id_rs, id_rt, id_rd, id_funct, id_imm6}), 32'd0);
    chk({pfx, "_req"}, 32'(imem_req), 32'd0);
    chk({pfx, "_addr"}, imem_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    exp_t        rec;
    logic [31:0] exp_pc;
    logic [31:0] hold_pc;

    tbl[0] = '{16'h1A2B, 4'h1, 3'd5, 3'd0, 3'd5, 3'd3, 6'h2B};
    tbl[1] = '{16'h3C4D, 4'h3, 3'd6, 3'd1, 3'd1, 3'd5, 6'h0D};
    tbl[2] = '{16'hFFFF, 4'hF, 3'd7, 3'd7, 3'd7, 3'd7, 6'h3F};
    tbl[3] = '{16'h8A51, 4'h8, 3'd5, 3'd1, 3'd2, 3'd1, 6'h11};

    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_valid = 1'b0; imem_rdata = 16'h0;
    step(); step();
    chk_zero("rst");

    // BOOT idle cycle, then first request
    reset_n = 1'b1;
    chk("boot_req", 32'(imem_req), 32'd0);
    step();
    chk("first_req", 32'(imem_req), 32'd1);

    // Zero-wait back-to-back fetch
    for (int i = 0; i < 4; i++) begin
      rec.pc = 32'(2 * i); rec.word = tbl[i].word; rec.op = tbl[i].op;
      rec.rs = tbl[i].rs; rec.rt = tbl[i].rt; rec.rd = tbl[i].rd; rec.fn = tbl[i].fn; rec.imm = tbl[i].imm;
      respond(rec, 1'b0, 1'b1);
    end
    exp_pc = 32'h8;

    // Three-cycle memory latency with bubbles
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < 2; w++) begin
        chk("lat_req", 32'(imem_req), 32'd1);
        chk("lat_addr", imem_addr, exp_pc);
        step();
        chk("lat_bubble", 32'(id_valid), 32'd0);
      end
      respond(mk(exp_pc, (f == 0) ? 16'h0123 : 16'h4567), 1'b0, 1'b1);
      exp_pc += 32'd2;
    end

    // Response under stall goes to the skid buffer
    hold_pc = last.pc;
    respond(mk(exp_pc, 16'hF03F), 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_valid", 32'(id_valid), 32'd1);
      chk("hold_pc", id_pc, hold_pc);
      if (k < 3) step();
    end
    stall = 1'b0;
    step();
    chk("skid_pc", id_pc, exp_pc);
    chk("skid_imm6", 32'(id_imm6), 32'h3F);
    chk("skid_rs", 32'(id_rs), 32'd0);
    exp_pc += 32'd2;
    chk("post_skid_req", 32'(imem_req), 32'd1);
    chk("post_skid_addr", imem_addr, exp_pc);

    // Redirect coinciding with a response, stall low
    imem_valid = 1'b1; imem_rdata = 16'hDEAD; branch_taken = 1'b1; branch_target = 32'h100;
    step();
    imem_valid = 1'b0; branch_taken = 1'b0;
    chk("br_kill", 32'(id_valid), 32'd0);
    chk("br_idle", 32'(imem_req), 32'd0);
    step();
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_addr", imem_addr, 32'h100);
    respond(mk(32'h100, 16'h1234), 1'b0, 1'b1);

    // Same with stall high
    imem_valid = 1'b1; imem_rdata = 16'hDEAD; branch_taken = 1'b1; stall = 1'b1;
    step();
    imem_valid = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    chk("brs_kill", 32'(id_valid), 32'd0);
    chk("brs_idle", 32'(imem_req), 32'd0);
    step();
    chk("brs_addr", imem_addr, 32'h100);
    respond(mk(32'h100, 16'h5678), 1'b0, 1'b1);

    // Redirect out of HOLD, then a second redirect while in BOOT
    respond(mk(32'h102, 16'hBEEF), 1'b1, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    chk("brh_kill", 32'(id_valid), 32'd0);
    chk("brh_idle", 32'(imem_req), 32'd0);
    branch_target = 32'h300; stall = 1'b0;
    step();
    branch_taken = 1'b0;
    chk("brb_idle", 32'(imem_req), 32'd0);
    step();
    chk("brb_req", 32'(imem_req), 32'd1);
    chk("brb_addr", imem_addr, 32'h300);

    // Reset while a fetch is outstanding at 0x20, late response ignored
    branch_taken = 1'b1; branch_target = 32'h20;
    step();
    branch_taken = 1'b0;
    step();
    chk("out_addr", imem_addr, 32'h20);
    step();
    reset_n = 1'b0; imem_valid = 1'b1; imem_rdata = 16'h7777;
    step();
    chk_zero("mid_rst");
    step();
    reset_n = 1'b1; imem_valid = 1'b0;
    chk("rst2_boot", 32'(imem_req), 32'd0);
    step();
    respond(mk(32'h0, 16'h2222), 1'b0, 1'b1);

    // PC wraps modulo 2^32
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    step();
    branch_taken = 1'b0;
    step();
    respond(mk(32'hFFFF_FFFE, 16'h4321), 1'b0, 1'b1);
    chk("wrap_pc_next", id_pc_next, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", 32'(imem_req), 32'd1);

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
